// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
// Defaults describe 640x480@60 VGA; totals and RGB bus width are derived here.
package video_timing_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_CNT_W    = 11;
   localparam int VGA_COLOR_W  = 4;

   // Per-pixel raster flags carried down the compensation delay line.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
   } raster_flags_t;

   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int rgb_width(input int color_w);
      return 3 * color_w;
   endfunction

endpackage

// File: rtl/video_timing_delay.sv
// Resettable shift register advancing only on clk_en ticks.
// Latency DEPTH ticks; no backpressure, clk_en low simply holds every stage.
module video_timing_delay #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (clk_en) begin
         stage_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, render strobes, line interrupt and registered DAC outputs.
// Pins lag the counters by PIPE_DELAY+1 clk_en ticks; no backpressure, clk_en low freezes all state.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE    = VGA_H_ACTIVE,
   parameter int H_FP        = VGA_H_FP,
   parameter int H_SYNC      = VGA_H_SYNC,
   parameter int H_BP        = VGA_H_BP,
   parameter int V_ACTIVE    = VGA_V_ACTIVE,
   parameter int V_FP        = VGA_V_FP,
   parameter int V_SYNC      = VGA_V_SYNC,
   parameter int V_BP        = VGA_V_BP,
   parameter int CNT_W       = VGA_CNT_W,
   parameter int COLOR_W     = VGA_COLOR_W,
   parameter int PIPE_DELAY  = 2,
   parameter int RENDER_LEAD = 1,
   parameter bit HSYNC_POL   = 1'b0,
   parameter bit VSYNC_POL   = 1'b0
) (
   input  logic                            rst,
   input  logic                            clk,
   input  logic                            clk_en,
   input  logic                            enable,
   input  logic [CNT_W-1:0]                irq_line,
   input  logic [rgb_width(COLOR_W)-1:0]   palette_rgb_data,
   output logic                            next_frame,
   output logic                            next_line,
   output logic                            next_pixel,
   output logic                            vblank_pulse,
   output logic                            line_irq,
   output logic [CNT_W-1:0]                x_pos,
   output logic [CNT_W-1:0]                y_pos,
   output logic [COLOR_W-1:0]              vga_r,
   output logic [COLOR_W-1:0]              vga_g,
   output logic [COLOR_W-1:0]              vga_b,
   output logic                            vga_hsync,
   output logic                            vga_vsync,
   output logic                            vga_de
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int RGB_W   = rgb_width(COLOR_W);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] VBLANK_Y = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] FRAME_Y  = CNT_W'(V_TOTAL - 1 - RENDER_LEAD);

   if (64'(H_TOTAL - 1) >= (64'd1 << CNT_W) || 64'(V_TOTAL - 1) >= (64'd1 << CNT_W)) begin : g_cnt_w_chk
      $error("video_timing_gen: CNT_W too narrow for the raster totals");
   end
   if (RENDER_LEAD < 0 || RENDER_LEAD > V_FP + V_SYNC + V_BP - 1) begin : g_lead_chk
      $error("video_timing_gen: RENDER_LEAD outside the vertical blanking interval");
   end
   if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_delay_chk
      $error("video_timing_gen: PIPE_DELAY must be 1..8");
   end

   logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
   logic             h_last, tick;

   assign h_last = (x_q == H_LAST);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (!enable) begin
         x_d = '0;
         y_d = '0;
      end else if (clk_en) begin
         if (h_last) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
         end else begin
            x_d = x_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   // Strobes are combinational so the composer sees them in the same tick as the position.
   assign tick         = clk_en && enable && !rst;
   assign next_pixel   = tick;
   assign next_line    = tick && h_last;
   assign next_frame   = tick && h_last && (y_q == FRAME_Y);
   assign vblank_pulse = tick && h_last && (y_q == VBLANK_Y);
   assign line_irq     = tick && h_last && (y_q == irq_line);
   assign x_pos        = x_q;
   assign y_pos        = y_q;

   raster_flags_t raw_flags, dly_flags;
   logic [$bits(raster_flags_t)-1:0] dly_bits;

   always_comb begin
      raw_flags        = '0;
      raw_flags.hsync  = enable && (x_q >= HS_BEG) && (x_q < HS_END);
      raw_flags.vsync  = enable && (y_q >= VS_BEG) && (y_q < VS_END);
      raw_flags.active = enable && (x_q < H_ACT) && (y_q < V_ACT);
   end

   video_timing_delay #(
      .WIDTH ($bits(raster_flags_t)),
      .DEPTH (PIPE_DELAY)
   ) u_delay (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .din_i  (raw_flags),
      .dout_o (dly_bits)
   );

   assign dly_flags = raster_flags_t'(dly_bits);

   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;

   always_comb begin
      rgb_d = rgb_q;
      de_d  = de_q;
      hs_d  = hs_q;
      vs_d  = vs_q;
      if (clk_en) begin
         rgb_d = dly_flags.active ? palette_rgb_data : '0;
         de_d  = dly_flags.active;
         hs_d  = ~(dly_flags.hsync ^ HSYNC_POL);
         vs_d  = ~(dly_flags.vsync ^ VSYNC_POL);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_q <= '0;
         de_q  <= 1'b0;
         hs_q  <= ~HSYNC_POL;
         vs_q  <= ~VSYNC_POL;
      end else begin
         rgb_q <= rgb_d;
         de_q  <= de_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
      end
   end

   assign vga_r     = rgb_q[RGB_W-1 -: COLOR_W];
   assign vga_g     = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign vga_b     = rgb_q[COLOR_W-1:0];
   assign vga_de    = de_q;
   assign vga_hsync = hs_q;
   assign vga_vsync = vs_q;

endmodule
